// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: registered N-way arbiter, fixed priority or round-robin.
// The winner is held until the consumer acknowledges it.
module prio_arbiter_rr #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         gnt_ack,
   output logic [W-1:0] gnt_idx,
   output logic [N-1:0] gnt_onehot,
   output logic         gnt_valid
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]   state;
   logic [W-1:0] ptr;
   logic [W-1:0] ptr_inc;
   logic [W-1:0] ptr_use;
   logic [W-1:0] win_idx;
   logic         any_req;

   function automatic logic [W-1:0] win(
      input logic [N-1:0] r,
      input logic         m,
      input logic [W-1:0] p
   );
      logic [W-1:0] w;
      int           j;
      w = '0;
      if (!m) begin
         for (int i = 0; i < N; i++)
            if (r[i]) w = W'(i);
      end else begin
         // scan from farthest offset down so the nearest one to p wins
         for (int k = N - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= N) j = j - N;
            if (r[W'(j)]) w = W'(j);
         end
      end
      return w;
   endfunction

   always_comb begin
      ptr_inc = (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
      ptr_use = ptr;
      if (state == GRANT && mode) ptr_use = ptr_inc;
      any_req = |req;
      win_idx = win(req, mode, ptr_use);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         gnt_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_idx    <= win_idx;
                  gnt_onehot <= N'(1) << win_idx;
                  gnt_valid  <= 1'b1;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (gnt_ack) begin
                  if (mode) ptr <= ptr_inc;
                  if (any_req) begin
                     gnt_idx    <= win_idx;
                     gnt_onehot <= N'(1) << win_idx;
                  end else begin
                     gnt_onehot <= '0;
                     gnt_valid  <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// tb_prio_arbiter_rr: directed steps with an expectation queue per DUT.
// Covers N=8 (fixed, round-robin, lock) and N=5 (wrap, reset mid-grant).
module tb_prio_arbiter_rr;

   typedef struct {
      logic  v;
      int    idx;
      string tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst8 = 1'b1, mode8 = 1'b0, ack8 = 1'b0;
   logic [7:0] req8 = '0;
   logic [2:0] gi8;
   logic [7:0] go8;
   logic       gv8;
   logic       rst5 = 1'b1, mode5 = 1'b0, ack5 = 1'b0;
   logic [4:0] req5 = '0;
   logic [2:0] gi5;
   logic [4:0] go5;
   logic       gv5;

   int   errors = 0;
   int   checks = 0;
   exp_t q8[$];
   exp_t q5[$];

   always #5 clk = ~clk;

   prio_arbiter_rr #(.N(8)) dut8 (
      .clk(clk), .rst(rst8), .req(req8), .mode(mode8),
      .gnt_ack(ack8), .gnt_idx(gi8), .gnt_onehot(go8),
      .gnt_valid(gv8)
   );

   prio_arbiter_rr #(.N(5)) dut5 (
      .clk(clk), .rst(rst5), .req(req5), .mode(mode5),
      .gnt_ack(ack5), .gnt_idx(gi5), .gnt_onehot(go5),
      .gnt_valid(gv5)
   );

   task automatic chk(input string tag, input string what,
                      input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s %s: got %0h want %0h", tag, what, got, want);
      end
   endtask

   task automatic step8(input logic r, input logic [7:0] q,
                        input logic m, input logic a,
                        input logic ev, input int ei, input string tag);
      exp_t e;
      logic [31:0] oh;
      rst8 = r; req8 = q; mode8 = m; ack8 = a;
      q8.push_back('{ev, ei, tag});
      @(posedge clk); #1;
      e = q8.pop_front();
      oh = e.v ? (32'd1 << e.idx) : 32'd0;
      chk(e.tag, "valid", 32'(gv8), 32'(e.v));
      chk(e.tag, "idx", 32'(gi8), 32'(e.idx));
      chk(e.tag, "onehot", 32'(go8), oh);
   endtask

   task automatic step5(input logic r, input logic [4:0] q,
                        input logic m, input logic a,
                        input logic ev, input int ei, input string tag);
      exp_t e;
      logic [31:0] oh;
      rst5 = r; req5 = q; mode5 = m; ack5 = a;
      q5.push_back('{ev, ei, tag});
      @(posedge clk); #1;
      e = q5.pop_front();
      oh = e.v ? (32'd1 << e.idx) : 32'd0;
      chk(e.tag, "valid", 32'(gv5), 32'(e.v));
      chk(e.tag, "idx", 32'(gi5), 32'(e.idx));
      chk(e.tag, "onehot", 32'(go5), oh);
   endtask

   initial begin
      // reset and idle
      step8(1, 8'h00, 0, 0, 0, 0, "rst0");
      step8(1, 8'h00, 0, 0, 0, 0, "rst1");
      for (int i = 0; i < 5; i++)
         step8(0, 8'h00, 0, 0, 0, 0, "idle");

      // fixed priority, frozen without ack, back-to-back on ack
      step8(0, 8'hAA, 0, 0, 1, 7, "fp_first");
      step8(0, 8'h55, 0, 0, 1, 7, "fp_hold0");
      step8(0, 8'h55, 0, 0, 1, 7, "fp_hold1");
      step8(0, 8'h55, 0, 1, 1, 6, "fp_ack");
      step8(0, 8'h55, 0, 1, 1, 6, "fp_regrant");
      step8(0, 8'h00, 0, 1, 0, 6, "fp_release");

      // round-robin full rotation (ptr still 0)
      step8(0, 8'hFF, 1, 0, 1, 0, "rr_first");
      for (int i = 1; i <= 8; i++)
         step8(0, 8'hFF, 1, 1, 1, i % 8, "rr_rot");
      step8(0, 8'h00, 1, 1, 0, 0, "rr_release");

      // sparse round-robin, ptr now 1
      step8(0, 8'h82, 1, 0, 1, 1, "sp_first");
      step8(0, 8'h82, 1, 1, 1, 7, "sp_a");
      step8(0, 8'h82, 1, 1, 1, 1, "sp_b");
      step8(0, 8'h82, 1, 1, 1, 7, "sp_c");
      step8(0, 8'h00, 1, 1, 0, 7, "sp_idle");

      // lock with dropped req, ptr now 0
      step8(0, 8'h08, 1, 0, 1, 3, "lk_first");
      for (int i = 0; i < 4; i++)
         step8(0, 8'h00, 1, 0, 1, 3, "lk_hold");
      step8(0, 8'h00, 1, 1, 0, 3, "lk_release");
      step8(0, 8'h00, 1, 1, 0, 3, "spur0");
      step8(0, 8'h00, 1, 1, 0, 3, "spur1");
      // ptr=4 untouched by the spurious acks
      step8(0, 8'hFF, 1, 0, 1, 4, "ptr_kept");
      step8(0, 8'hFF, 0, 1, 1, 7, "mode0_ack");
      step8(0, 8'h00, 0, 1, 0, 7, "mode0_rel");
      step8(0, 8'hFF, 1, 0, 1, 4, "mode1_resume");
      step8(1, 8'hFF, 1, 0, 0, 0, "rst_mid8");
      step8(0, 8'hFF, 1, 0, 1, 0, "post_rst8");

      // N=5: wrap and reset mid-grant
      step5(1, 5'h00, 1, 0, 0, 0, "n5_rst");
      step5(0, 5'h1F, 1, 0, 1, 0, "n5_first");
      for (int i = 1; i <= 9; i++)
         step5(0, 5'h1F, 1, 1, 1, i % 5, "n5_rot");
      step5(1, 5'h1F, 1, 0, 0, 0, "n5_rst_mid");
      step5(0, 5'h1F, 1, 0, 1, 0, "n5_post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prio_arbiter_rr.md
Name: prio_arbiter_rr

Overview:
- Parametrised, registered N-way priority arbiter.
- Replaces the combinational 8-to-3 priority encoder wherever a requester must hold ownership until it finishes.
- Selects one active request per arbitration, either by fixed priority (highest index wins) or round-robin.
- Presents the winner as an index plus a one-hot grant, and holds it stable until the consumer acknowledges.

Parameters:
- N, 8, number of request lines (N >= 2).
- W, $clog2(N), index width. Derived; never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- gnt_ack  input  1  consumer has finished with the current grant; ignored while gnt_valid=0.
- gnt_idx  output  W  index of the granted requester; registered.
- gnt_onehot  output  N  one-hot grant; equals 1<<gnt_idx when gnt_valid=1, else 0; registered.
- gnt_valid  output  1  a grant is held; registered.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=0. rst overrides all other inputs in that cycle.
- State machine has two states, IDLE and GRANT.
- Arbitration function win(req, mode, ptr):
  - mode=0: highest set index of req.
  - mode=1: first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
  - Result is defined only when req != 0.
- IDLE:
  - If req != 0: load gnt_idx=win and gnt_onehot=1<<win, set gnt_valid=1, go to GRANT. Latency is 1 clock from req asserted to gnt_valid.
  - If req == 0: stay in IDLE; outputs hold their reset/cleared values.
- GRANT:
  - Outputs are frozen while gnt_ack=0, regardless of req or mode changes.
  - Dropping the granted req bit does not release the grant; only gnt_ack releases it.
- GRANT with gnt_ack=1:
  - ptr_next = (gnt_idx+1) mod N when mode=1; ptr is unchanged when mode=0.
  - Re-arbitrate in the same cycle using ptr_next and the current req.
  - If the result is nonzero: load the new winner, keep gnt_valid=1, stay in GRANT. This gives back-to-back grants with no bubble.
  - If req == 0: clear gnt_valid and gnt_onehot, go to IDLE. gnt_idx keeps its last value.
- The granted requester may win again immediately only if it is the sole requester, or if mode=0 and it is still the highest-index requester.
- ptr is W bits wide. ptr wraps from N-1 to 0, and the modulo is correct for non-power-of-2 N.
- mode is sampled only on arbitration cycles (IDLE with req!=0, or GRANT with ack). Switching to mode=0 leaves ptr unchanged. Switching back to mode=1 resumes from the retained ptr.
- gnt_ack=1 while gnt_valid=0 has no effect.
- Reset asserted mid-grant drops the grant in the next cycle, with no ack required.
- Invariants checked every cycle:
  - $onehot0(gnt_onehot).
  - gnt_onehot != 0 iff gnt_valid.
  - If gnt_valid=1, then gnt_onehot == 1<<gnt_idx.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then req=0 for 5 cycles. gnt_valid=0, gnt_idx=0, gnt_onehot=0 throughout.
- Fixed-priority legacy check:
  - mode=0, req=8'b10101010. One cycle later gnt_idx=7, gnt_onehot=8'b10000000, gnt_valid=1.
  - Change req to 8'b01010101 without ack: outputs unchanged.
  - Ack: gnt_idx=6 the next cycle, no bubble.
- Round-robin rotation:
  - mode=1, req=8'b11111111 held, gnt_ack=1 every cycle while valid.
  - gnt_idx sequence is 0,1,2,...,7,0 with gnt_valid continuously 1 after the first grant.
- Sparse round-robin with wrap:
  - mode=1, req=8'b10000010 held.
  - Grants alternate 1,7,1,7 on successive acks.
  - Then drop req to 0 during the ack: gnt_valid=0 the next cycle and the FSM returns to IDLE.
- Lock and spurious ack:
  - Grant index 3 with req=8'b00001000, then deassert req[3] while gnt_ack=0 for 4 cycles: grant is held at 3.
  - gnt_ack pulsed while gnt_valid=0 causes no state change.
- Reset mid-grant and non-power-of-2 N:
  - N=5, mode=1, req=5'b11111, grant at idx 4. Assert rst: gnt_valid=0 next cycle and ptr=0.
  - After reset, the first grant is idx 0.
